// File: rtl/fifo_drain.sv
// Read-side sequencer for the shift-register delay fifo: on start, shifts out every entry
// oldest first onto a registered valid/ready stream, refilling the fifo with zeros.
module fifo_drain #(
    parameter int DEPTH = 8,
    parameter int BITS  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     fifo_en,
    output logic [BITS-1:0]          fifo_d,
    input  logic [BITS-1:0]          fifo_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITS-1:0]          out_data,
    output logic [$clog2(DEPTH)-1:0] out_idx
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   issue_cnt;
    logic            accept;
    logic            load;
    logic            all_issued;

    assign all_issued = (issue_cnt == LAST);
    assign accept     = out_valid & out_ready;
    // A word is pulled whenever the output register is empty or being emptied this cycle.
    assign load       = (state == DRAIN) & (issue_cnt < LAST) & (~out_valid | out_ready);
    assign fifo_en    = load;
    assign fifo_d     = '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            issue_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DRAIN;
                        busy      <= 1'b1;
                        issue_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (load) begin
                        out_data  <= fifo_q;
                        out_idx   <= issue_cnt[IW-1:0];
                        out_valid <= 1'b1;
                        issue_cnt <= issue_cnt + CW'(1);
                    end else if (accept) begin
                        out_valid <= 1'b0;
                    end
                    if (all_issued && (!out_valid || accept)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: a behavioural shift fifo, a queue-based reference of its contents,
// and a scoreboard monitor that checks every accepted word plus handshake/timing rules.
module tb_fifo_drain;

    localparam int DEPTH = 8;
    localparam int BITS  = 64;
    localparam int IW    = $clog2(DEPTH);

    logic            clk = 1'b0;
    logic            rst_n, start, push, fifo_clr, out_ready;
    logic [BITS-1:0] push_d;
    logic            busy, done, fifo_en, out_valid;
    logic [BITS-1:0] fifo_d, fifo_q, out_data;
    logic [IW-1:0]   out_idx;

    always #5 clk = ~clk;

    fifo_drain #(.DEPTH(DEPTH), .BITS(BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fifo_en   (fifo_en),
        .fifo_d    (fifo_d),
        .fifo_q    (fifo_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx)
    );

    // Attached delay fifo: entry DEPTH-1 is the oldest; not cleared by the block's reset.
    logic [BITS-1:0] fr [DEPTH];
    assign fifo_q = fr[DEPTH-1];
    always @(posedge clk) begin
        if (fifo_clr) begin
            for (int i = 0; i < DEPTH; i++) fr[i] <= '0;
        end else if (fifo_en || push) begin
            for (int i = DEPTH-1; i > 0; i--) fr[i] <= fr[i-1];
            fr[0] <= fifo_en ? fifo_d : push_d;
        end
    end

    int   n_chk = 0, n_fail = 0;
    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: fifo contents oldest-first, and the words each drain must return.
    logic [BITS-1:0] mq[$];
    logic [BITS-1:0] exp_d[$];
    int              exp_i[$];

    int              m_state = 0;   // 0 idle, 1 draining, 2 done cycle
    int              m_acc, en_cnt, t_start, acc_cnt = 0;
    bit              seen_valid, all_ready, prev_stall = 0;
    logic [BITS-1:0] prev_d, fr_or;
    logic [IW-1:0]   prev_i;

    always @(negedge clk) begin
        if (cyc != 0) begin
            if (!rst_q) begin
                chk("rst_busy", 64'(busy), 0);
                chk("rst_done", 64'(done), 0);
                chk("rst_valid", 64'(out_valid), 0);
                chk("rst_data", out_data, 0);
                chk("rst_idx", 64'(out_idx), 0);
                chk("rst_fifo_en", 64'(fifo_en), 0);
                m_state = 0;
                exp_d.delete();
                exp_i.delete();
                prev_stall = 0;
            end else begin
                chk("busy", 64'(busy), 64'(m_state != 0));
                chk("done", 64'(done), 64'(m_state == 2));
                if (m_state != 1) chk("fifo_en_outside_drain", 64'(fifo_en), 0);
                if (m_state == 0) chk("valid_idle", 64'(out_valid), 0);
                if (fifo_en) chk("fifo_d_zero", fifo_d, 0);
                if (prev_stall) begin
                    chk("stall_valid", 64'(out_valid), 1);
                    chk("stall_data", out_data, prev_d);
                    chk("stall_idx", 64'(out_idx), 64'(prev_i));
                end
                if (out_valid && !out_ready) chk("stall_fifo_en", 64'(fifo_en), 0);
                prev_stall = out_valid && !out_ready;
                prev_d     = out_data;
                prev_i     = out_idx;
                if (m_state == 1 && out_valid && !seen_valid) begin
                    chk("first_valid_latency", 64'(cyc), 64'(t_start + 2));
                    seen_valid = 1;
                end
                if (m_state == 1 && !out_ready) all_ready = 0;
                if (fifo_en) en_cnt++;
                if (out_valid && out_ready) begin
                    acc_cnt++;
                    m_acc++;
                    if (exp_d.size() == 0) begin
                        chk("unexpected_word", 64'(out_idx), 64'hdead);
                    end else begin
                        chk("data", out_data, exp_d.pop_front());
                        chk("idx", 64'(out_idx), 64'(exp_i.pop_front()));
                    end
                end
                case (m_state)
                    0: if (start) begin
                        m_state = 1;
                        m_acc = 0; en_cnt = 0; t_start = cyc;
                        seen_valid = 0; all_ready = 1;
                        for (int i = 0; i < DEPTH; i++) begin
                            exp_d.push_back(mq[i]);
                            exp_i.push_back(i);
                        end
                    end
                    1: if (m_acc == DEPTH) m_state = 2;
                    default: begin
                        chk("fifo_en_pulses", 64'(en_cnt), 64'(DEPTH));
                        chk("words_left", 64'(exp_d.size()), 0);
                        fr_or = '0;
                        for (int i = 0; i < DEPTH; i++) fr_or |= fr[i];
                        chk("fifo_zero_after_drain", fr_or, 0);
                        if (all_ready) chk("done_latency", 64'(cyc), 64'(t_start + DEPTH + 2));
                        m_state = 0;
                    end
                endcase
            end
            if (fifo_en === 1'b1) begin
                void'(mq.pop_front());
                mq.push_back(fifo_d);
            end else if (push) begin
                void'(mq.pop_front());
                mq.push_back(push_d);
            end
        end
    end

    // out_ready patterns: 0 always ready, 1 the 1,0,0 cycle, 2 random.
    int mode = 0;
    int ph = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (ph % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    task automatic push_word(input logic [BITS-1:0] d);
        @(posedge clk); #1;
        push = 1'b1; push_d = d;
        @(posedge clk); #1;
        push = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no done, expected done within 400 cycles");
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) push_word({$urandom, $urandom});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; push = 1'b0; push_d = '0; fifo_clr = 1'b1;
        for (int i = 0; i < DEPTH; i++) mq.push_back('0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; fifo_clr = 1'b0;
        repeat (4) @(posedge clk);

        // Known pattern at full rate: oldest entry is 1.
        mode = 0;
        for (int i = 1; i <= DEPTH; i++) push_word(BITS'(i));
        pulse_start();
        wait_done();

        // 1,0,0 backpressure.
        fill_random();
        mode = 1;
        pulse_start();
        wait_done();

        // Second start mid-drain must be ignored.
        fill_random();
        mode = 2;
        pulse_start();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);

        // Reset after three accepts, then drain what is left.
        fill_random();
        mode = 0;
        begin
            int base = acc_cnt;
            pulse_start();
            for (int i = 0; i < 100 && acc_cnt < base + 3; i++) @(posedge clk);
            #1 rst_n = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
        end
        pulse_start();
        wait_done();

        // Back-to-back: restart in the cycle right after done.
        fill_random();
        pulse_start();
        wait_done();
        pulse_start();
        wait_done();

        // Random drains with random backpressure.
        mode = 2;
        for (int r = 0; r < 3; r++) begin
            fill_random();
            pulse_start();
            wait_done();
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
